// File: rtl/float8_accumulator_if.sv
// Handshake bundle for float8_accumulator: term input stream and finished-sum output stream.
// A beat transfers on a rising edge where valid && ready; the source holds payload stable until then.
interface float8_accumulator_if #(
  parameter int COUNT_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [7:0]         in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         out_data;
  logic [COUNT_W-1:0] out_count;
  logic               out_ovf;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_ovf
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_ovf
  );
endinterface

// File: rtl/float8_accumulator.sv
// Sequential float8 (1-3-4, bias 3) running-sum stage: one term per 4 cycles, sum emitted on last.
// Define FLOAT8_ACC_ROUND_EN for round-to-nearest-even; otherwise results truncate toward zero.
module float8_accumulator #(
  parameter int COUNT_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  float8_accumulator_if.slave bus,
  output logic [2:0]          dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    OUT   = 3'd4
  } state_t;

  state_t             state_q;
  logic [7:0]         in_q, acc_q;
  logic               last_q;
  logic [COUNT_W-1:0] count_q;
  logic               ovf_q;
  logic [7:0]         big_sig_q, small_sig_q;
  logic               big_s_q, small_s_q;
  logic [2:0]         exp_q;
  logic [8:0]         sum_q;
  logic               sum_s_q;

  // Align: significands are {1, frac, g, r, s}; zero-exponent operands flush to +0.
  logic       a_zero, b_zero, a_s, b_s;
  logic [7:0] a_sig, b_sig, small_pre, lost_mask;
  logic [2:0] diff;
  logic [7:0] big_sig_d, small_sig_d;
  logic       big_s_d, small_s_d;
  logic [2:0] exp_d;

  always_comb begin
    a_zero = (acc_q[6:4] == 3'd0);
    b_zero = (in_q[6:4] == 3'd0);
    a_sig  = a_zero ? 8'h00 : {1'b1, acc_q[3:0], 3'b000};
    b_sig  = b_zero ? 8'h00 : {1'b1, in_q[3:0], 3'b000};
    a_s    = acc_q[7] & ~a_zero;
    b_s    = in_q[7] & ~b_zero;
    if (acc_q[6:4] >= in_q[6:4]) begin
      big_sig_d = a_sig;  big_s_d = a_s;  exp_d = acc_q[6:4];
      small_pre = b_sig;  small_s_d = b_s;
      diff      = acc_q[6:4] - in_q[6:4];
    end else begin
      big_sig_d = b_sig;  big_s_d = b_s;  exp_d = in_q[6:4];
      small_pre = a_sig;  small_s_d = a_s;
      diff      = in_q[6:4] - acc_q[6:4];
    end
    // Exponent gap is at most 7, so every shifted-out bit folds into the sticky LSB.
    lost_mask   = (8'h01 << diff) - 8'h01;
    small_sig_d = (small_pre >> diff) | {7'd0, |(small_pre & lost_mask)};
  end

  logic [8:0] sum_d;
  logic       sum_s_d;

  always_comb begin
    if (big_s_q == small_s_q) begin
      sum_d   = {1'b0, big_sig_q} + {1'b0, small_sig_q};
      sum_s_d = big_s_q;
    end else if (big_sig_q >= small_sig_q) begin
      sum_d   = {1'b0, big_sig_q - small_sig_q};
      sum_s_d = big_s_q;
    end else begin
      sum_d   = {1'b0, small_sig_q - big_sig_q};
      sum_s_d = small_s_q;
    end
  end

  logic [2:0]        lead, shl;
  logic [7:0]        norm;
  logic [3:0]        frac;
  logic              g, st, rnd, is_zero, sat_d;
  logic signed [5:0] e_n, res_e;
  logic [9:0]        packed_r;
  logic [7:0]        acc_d;

  always_comb begin
    lead = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (sum_q[i]) lead = 3'(i);
    end
    shl     = 3'd7 - lead;
    norm    = sum_q[7:0] << shl;
    is_zero = ~sum_q[8] & ~norm[7];
    if (sum_q[8]) begin
      frac = sum_q[7:4];
      g    = sum_q[3];
      st   = |sum_q[2:0];
      e_n  = $signed({3'b000, exp_q}) + 6'sd1;
    end else begin
      frac = norm[6:3];
      g    = norm[2];
      st   = |norm[1:0];
      e_n  = $signed({3'b000, exp_q}) - $signed({3'b000, shl});
    end
`ifdef FLOAT8_ACC_ROUND_EN
    rnd = g & (st | frac[0]);
`else
    rnd = &{1'b0, g, st};
`endif
    // Exponent and fraction are added as one word so a rounding carry renormalises itself.
    packed_r = {e_n, frac} + {9'd0, rnd};
    res_e    = $signed(packed_r[9:4]);
    sat_d    = 1'b0;
    if (is_zero) begin
      acc_d = 8'h00;
    end else if (res_e > 6'sd7) begin
      acc_d = {sum_s_q, 7'h7f};
      sat_d = 1'b1;
    end else if (res_e < 6'sd1) begin
      acc_d = 8'h00;
    end else begin
      acc_d = {sum_s_q, res_e[2:0], packed_r[3:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_q        <= '0;
      last_q      <= 1'b0;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      big_sig_q   <= '0;
      small_sig_q <= '0;
      big_s_q     <= 1'b0;
      small_s_q   <= 1'b0;
      exp_q       <= '0;
      sum_q       <= '0;
      sum_s_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          in_q    <= bus.in_data;
          last_q  <= bus.in_last;
          if (count_q != '1) count_q <= count_q + COUNT_W'(1);
          state_q <= ALIGN;
        end
        ALIGN: begin
          big_sig_q   <= big_sig_d;
          small_sig_q <= small_sig_d;
          big_s_q     <= big_s_d;
          small_s_q   <= small_s_d;
          exp_q       <= exp_d;
          state_q     <= ADD;
        end
        ADD: begin
          sum_q   <= sum_d;
          sum_s_q <= sum_s_d;
          state_q <= NORM;
        end
        NORM: begin
          acc_q   <= acc_d;
          if (sat_d) ovf_q <= 1'b1;
          state_q <= last_q ? OUT : IDLE;
        end
        OUT: if (bus.out_ready) begin
          acc_q   <= '0;
          count_q <= '0;
          ovf_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE) & ~rst;
  assign bus.out_valid = (state_q == OUT);
  assign bus.out_data  = acc_q;
  assign bus.out_count = count_q;
  assign bus.out_ovf   = ovf_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_float8_accumulator.sv
// Bench for float8_accumulator: directed packets plus random packets, scored against a real-valued model.
module tb_float8_accumulator;

  localparam int COUNT_W = 4;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;
  int         ready_mode;
  int         n_vec;
  int         n_err;
  logic [12:0] exp_q[$];

  logic [7:0] m_acc;
  int         m_count;
  bit         m_ovf;

  float8_accumulator_if #(.COUNT_W(COUNT_W)) bus ();

  float8_accumulator #(.COUNT_W(COUNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000ns, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic real pow2(input int e);
    real r;
    r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real f8_to_real(input logic [7:0] b);
    real m;
    if (b[6:4] == 3'd0) return 0.0;
    m = (16.0 + real'(b[3:0])) / 16.0 * pow2(int'(b[6:4]) - 3);
    return b[7] ? -m : m;
  endfunction

  function automatic logic [7:0] real_to_f8(input real v, output bit sat);
    real m, q;
    int  e, fi;
    bit  s;
    sat = 1'b0;
    if (v == 0.0) return 8'h00;
    s = (v < 0.0);
    m = s ? -v : v;
    e = 3;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    q  = m * 16.0;
    fi = $rtoi(q);
`ifdef FLOAT8_ACC_ROUND_EN
    begin
      real fr;
      fr = q - real'(fi);
      if (fr > 0.5 || (fr == 0.5 && (fi % 2) == 1)) fi++;
    end
`endif
    if (fi == 32) begin fi = 16; e++; end
    if (e > 7) begin sat = 1'b1; return {s, 7'h7f}; end
    if (e < 1) return 8'h00;
    return {s, e[2:0], fi[3:0]};
  endfunction

  task automatic model_clear();
    m_acc = 8'h00; m_count = 0; m_ovf = 1'b0;
  endtask

  task automatic model_accept(input logic [7:0] d, input logic l);
    bit sat;
    m_acc = real_to_f8(f8_to_real(m_acc) + f8_to_real(d), sat);
    if (sat) m_ovf = 1'b1;
    if (m_count < (1 << COUNT_W) - 1) m_count++;
    if (l) begin
      exp_q.push_back({m_ovf, 4'(m_count), m_acc});
      model_clear();
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that took the term.
  task automatic send_term(input logic [7:0] d, input logic l);
    bit hs;
    int guard;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = l;
    hs = 1'b0; guard = 0;
    while (!hs && guard < 100) begin
      @(negedge clk);
      hs = bus.in_ready;
      @(posedge clk);
      guard++;
    end
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    bus.in_last  = 1'($urandom);
    if (!hs) check("in_ready_timeout", 32'(hs), 32'd1);
    else model_accept(d, l);
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 300) begin @(posedge clk); g++; end
    #1;
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin : monitor
    logic [12:0] e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_output: got %0h with no expected sum pending", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data",  32'(bus.out_data),  32'(e[7:0]));
          check("out_count", 32'(bus.out_count), 32'(e[11:8]));
          check("out_ovf",   32'(bus.out_ovf),   32'(e[12]));
        end
      end
    end
  end

  initial begin
    n_vec = 0; n_err = 0;
    ready_mode = 1;
    model_clear();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_last = 1'b0;
    #1;
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_out_count", 32'(bus.out_count), 32'd0);
    check("rst_out_ovf",   32'(bus.out_ovf),   32'd0);
    check("rst_state",     32'(dbg_state),     32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Directed packets: 1+1, 1-1, overflow then fresh packet, rounding case.
    send_term(8'h30, 1'b0); send_term(8'h30, 1'b1);
    send_term(8'h30, 1'b0); send_term(8'hb0, 1'b1);
    send_term(8'h7f, 1'b0); send_term(8'h70, 1'b1);
    send_term(8'h30, 1'b1);
    send_term(8'h71, 1'b0); send_term(8'h20, 1'b1);
    wait_drain();

    // Output backpressure with a term waiting upstream.
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    send_term(8'h30, 1'b1);
    bus.in_valid = 1'b1; bus.in_data = 8'h40; bus.in_last = 1'b1;
    begin
      int g;
      g = 0;
      @(negedge clk);
      while (!bus.out_valid && g < 20) begin @(negedge clk); g++; end
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      for (int k = 0; k < 3; k++) begin
        check("bp_in_ready",  32'(bus.in_ready),  32'd0);
        check("bp_out_data",  32'(bus.out_data),  32'h30);
        check("bp_out_count", 32'(bus.out_count), 32'd1);
        @(negedge clk);
      end
    end
    ready_mode = 1;
    send_term(8'h40, 1'b1);
    wait_drain();

    // Reset while the second term of a packet sits in ADD.
    send_term(8'h30, 1'b0);
    send_term(8'h40, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("mid_rst_out_data",  32'(bus.out_data),  32'd0);
    check("mid_rst_out_count", 32'(bus.out_count), 32'd0);
    check("mid_rst_out_ovf",   32'(bus.out_ovf),   32'd0);
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    send_term(8'h48, 1'b1);
    wait_drain();

    // Random packets with random gaps and random output backpressure.
    ready_mode = 2;
    for (int p = 0; p < 40; p++) begin
      int len;
      len = (p == 20) ? 17 : $urandom_range(1, 6);
      for (int t = 0; t < len; t++) begin
        logic [7:0] d;
        d = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 7) == 0) d[6:4] = 3'd0;
        send_term(d, (t == len - 1));
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
    end
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
